// File: rtl/imem_loader_ram.sv
// imem_loader_ram
//   Writable instruction memory for sr_cpu. A program is streamed in over a
//   valid/ready word interface while the CPU is held in reset. Once the last
//   word is written, cpu_rst stays high for RESET_HOLD more edges and is then
//   released. CPU fetches use a combinational read port, as the ROM did.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   Adds input ld_sum. This value is latched on an accepted ld_start and
//   compared against the modulo-2^32 sum of the loaded words. On a mismatch
//   the loader returns to IDLE with err set instead of releasing the CPU.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ld_start/ld_len  load request and word count (1..SIZE is legal)
//   ld_valid/ld_data program word stream; ld_ready accepts a word
//   ld_sum           expected word sum (LOADER_CHECKSUM_EN only)
//   cpu_rst          reset to sr_cpu
//   busy/done/err    LOAD|HOLD, RUN, sticky length/checksum error
//   a/rd             fetch word address and instruction (NOP when a >= SIZE)
module imem_loader_ram #(
  parameter int unsigned SIZE       = 1024,
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic [31:0] ld_len,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0] ld_sum,
`endif
  output logic        ld_ready,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] a,
  output logic [31:0] rd
);

  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic        ld_ready_q, ld_ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] mem [SIZE];

  logic start_ok;
  logic beat;
  logic last;
  logic sum_ok;

  assign start_ok = (ld_len != '0) && (ld_len <= 32'(SIZE));
  assign beat     = (state_q == LOAD) && ld_valid && ld_ready_q;
  assign last     = beat && (cnt_q == len_q - 32'd1);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] exp_q, exp_d;
  // The last word is folded in combinationally so the check resolves on the
  // same edge that accepts that word.
  assign sum_ok = ((sum_q + ld_data) == exp_q);
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    exp_d   = exp_q;
`endif
    case (state_q)
      IDLE, RUN: begin
        if (ld_start) begin
          if (start_ok) begin
            state_d = LOAD;
            len_d   = ld_len;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
            exp_d   = ld_sum;
`endif
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          cnt_d = cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + ld_data;
`endif
          if (last) begin
            if (sum_ok) begin
              state_d = HOLD;
              hold_d  = 32'(RESET_HOLD);
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        // The counter is loaded on the last-beat edge, so release happens on
        // the edge where it reads 1: RESET_HOLD edges after that beat.
        hold_d = hold_q - 32'd1;
        if (hold_q <= 32'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // The outputs are registered from the next state, so they change on the
    // same edge as the state does.
    ld_ready_d = (state_d == LOAD);
    cpu_rst_d  = (state_d != RUN);
    busy_d     = (state_d == LOAD) || (state_d == HOLD);
    done_d     = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      exp_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      exp_q      <= exp_d;
`endif
    end
  end

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[cnt_q[AW-1:0]] <= ld_data;
    end
  end

  assign rd = (a < 32'(SIZE)) ? mem[a[AW-1:0]] : NOP;

  assign ld_ready = ld_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader_ram.sv
// Testbench for imem_loader_ram. Stimulus runs just after each rising edge
// and queues the expected responses. A monitor drains the queue at each
// falling edge.
module tb_imem_loader_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic [31:0] ld_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] a;
  logic [31:0] rd;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] ld_sum;
`endif

  always #5 clk = ~clk;

  imem_loader_ram #(.SIZE(1024), .RESET_HOLD(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
`ifdef LOADER_CHECKSUM_EN
    .ld_sum   (ld_sum),
`endif
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .a        (a),
    .rd       (rd)
  );

  // Status vector layout: {cpu_rst, ld_ready, busy, done, err}
  localparam logic [4:0] S_IDLE = 5'b10000;
  localparam logic [4:0] S_LOAD = 5'b11100;
  localparam logic [4:0] S_HOLD = 5'b10100;
  localparam logic [4:0] S_RUN  = 5'b00010;
  localparam logic [4:0] S_ERR  = 5'b10001;
  localparam logic [31:0] JUNK  = 32'hBAD0_BAD0;

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    tests = 0;
  int    fails = 0;

  item_t       mon_it;
  logic [31:0] mon_act;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_it  = sb.pop_front();
      mon_act = mon_it.is_rd ? rd : {27'b0, cpu_rst, ld_ready, busy, done, err};
      tests++;
      if (mon_act !== mon_it.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", mon_it.name, mon_act, mon_it.exp);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input string n, input logic [4:0] e);
    item_t it;
    it.name  = n;
    it.is_rd = 1'b0;
    it.exp   = {27'b0, e};
    sb.push_back(it);
  endtask

  task automatic exp_rd(input string n, input logic [31:0] addr, input logic [31:0] e);
    item_t it;
    a        = addr;
    it.name  = n;
    it.is_rd = 1'b1;
    it.exp   = e;
    sb.push_back(it);
  endtask

  task automatic start(input logic [31:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic beat(input string n, input logic v, input logic [31:0] d);
    ld_valid = v;
    ld_data  = d;
    exp_st(n, S_LOAD);
    tick();
    ld_valid = 1'b0;
  endtask

  // Entered just after the last-beat edge. ld_valid is held high with junk
  // data so that a write outside LOAD would show up in later reads.
  task automatic hold_to_run(input string n);
    ld_valid = 1'b1;
    ld_data  = JUNK;
    exp_st({n, "_hold1"}, S_HOLD);
    tick();
    exp_st({n, "_hold2"}, S_HOLD);
    tick();
    ld_valid = 1'b0;
    exp_st({n, "_run"}, S_RUN);
  endtask

  task automatic rd_tick(input string n, input logic [31:0] addr, input logic [31:0] e);
    exp_rd(n, addr, e);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    a        = 32'd2000;
`ifdef LOADER_CHECKSUM_EN
    ld_sum   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    exp_st("reset_status", S_IDLE);
    exp_rd("reset_rd_oob", 32'd2000, 32'h0000_0013);
    tick();
    rst = 1'b0;
    exp_st("idle_after_reset", S_IDLE);
    tick();

    // Basic load of four words
    start(32'd4);
    beat("basic_b0", 1'b1, 32'h0000_0513);
    beat("basic_b1", 1'b1, 32'h0010_0593);
    beat("basic_b2", 1'b1, 32'h00b5_0533);
    beat("basic_b3", 1'b1, 32'hff9f_f06f);
    hold_to_run("basic");
    rd_tick("basic_rd0", 32'd0, 32'h0000_0513);
    rd_tick("basic_rd1", 32'd1, 32'h0010_0593);
    rd_tick("basic_rd2", 32'd2, 32'h00b5_0533);
    rd_tick("basic_rd3", 32'd3, 32'hff9f_f06f);

    // Reload from RUN. Address 0 is also read while it is being written.
    start(32'd2);
    exp_rd("collide_old", 32'd0, 32'h0000_0513);
    beat("reload_b0", 1'b1, 32'h1111_1111);
    exp_rd("collide_new", 32'd0, 32'h1111_1111);
    beat("reload_b1", 1'b1, 32'h2222_2222);
    hold_to_run("reload");
    rd_tick("reload_rd0", 32'd0, 32'h1111_1111);
    rd_tick("reload_rd1", 32'd1, 32'h2222_2222);
    rd_tick("reload_rd2", 32'd2, 32'h00b5_0533);

    // Backpressure: ld_valid pattern 1,0,0,1,0,1
    start(32'd3);
    beat("bp_c1", 1'b1, 32'h0000_00B0);
    beat("bp_c2", 1'b0, JUNK);
    beat("bp_c3", 1'b0, JUNK);
    beat("bp_c4", 1'b1, 32'h0000_00B1);
    beat("bp_c5", 1'b0, JUNK);
    beat("bp_c6", 1'b1, 32'h0000_00B2);
    hold_to_run("bp");
    rd_tick("bp_rd0", 32'd0, 32'h0000_00B0);
    rd_tick("bp_rd1", 32'd1, 32'h0000_00B1);
    rd_tick("bp_rd2", 32'd2, 32'h0000_00B2);
    rd_tick("bp_rd3", 32'd3, 32'hff9f_f06f);

    // ld_valid in RUN must not write anything
    ld_valid = 1'b1;
    ld_data  = JUNK;
    tick();
    ld_valid = 1'b0;

    // Length errors, then a legal start that clears err
    start(32'd0);
    exp_st("len0_err", S_ERR);
    start(32'd1025);
    exp_st("len1025_err", S_ERR);
    tick();
    exp_st("err_sticky", S_ERR);
    start(32'd2);
    beat("legal_b0", 1'b1, 32'h0000_00C0);
    beat("legal_b1", 1'b1, 32'h0000_00C1);
    hold_to_run("legal");
    rd_tick("legal_rd0", 32'd0, 32'h0000_00C0);
    rd_tick("legal_rd1", 32'd1, 32'h0000_00C1);
    rd_tick("legal_rd2", 32'd2, 32'h0000_00B2);
    rd_tick("run_valid_ignored", 32'd3, 32'hff9f_f06f);

    // Asynchronous reset two beats into a four-word load
    start(32'd4);
    beat("midrst_b0", 1'b1, 32'h0000_00D0);
    beat("midrst_b1", 1'b1, 32'h0000_00D1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_st("midrst_idle", S_IDLE);
    tick();
    exp_st("midrst_idle2", S_IDLE);
    rd_tick("midrst_rd0", 32'd0, 32'h0000_00D0);
    rd_tick("midrst_rd1", 32'd1, 32'h0000_00D1);
    rd_tick("midrst_rd2", 32'd2, 32'h0000_00B2);
    rd_tick("midrst_rd3", 32'd3, 32'hff9f_f06f);
    rd_tick("rd_at_size", 32'd1024, 32'h0000_0013);

`ifdef LOADER_CHECKSUM_EN
    // 0x10000000 + 0x20000005 = 0x30000005
    ld_sum = 32'h3000_0004;
    start(32'd2);
    beat("sum_bad_b0", 1'b1, 32'h1000_0000);
    beat("sum_bad_b1", 1'b1, 32'h2000_0005);
    exp_st("sum_bad_err", S_ERR);
    tick();
    exp_st("sum_bad_stay", S_ERR);
    ld_sum = 32'h3000_0005;
    start(32'd2);
    beat("sum_ok_b0", 1'b1, 32'h1000_0000);
    beat("sum_ok_b1", 1'b1, 32'h2000_0005);
    hold_to_run("sum_ok");
    tick();
`endif

    tick();
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader_ram.md
Name: imem_loader_ram

Overview:
- Writable instruction memory that replaces the fixed instruction ROM in front of sr_cpu.
- Accepts a program as a valid/ready word stream and writes it into the RAM, holding the CPU in reset meanwhile.
- Releases the CPU once the load completes.
- Serves CPU fetches on a combinational read port with the same timing as the ROM.

Parameters:
- SIZE, 1024, RAM depth in 32-bit words.
- RESET_HOLD, 2, cycles cpu_rst stays high after the last word is accepted; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ld_start  input  1  single-cycle request to begin a load
- ld_len  input  32  word count; sampled when ld_start is accepted
- ld_valid  input  1  ld_data carries a word
- ld_data  input  32  program word
- ld_ready  output  1  loader accepts a word this cycle
- cpu_rst  output  1  reset to sr_cpu
- busy  output  1  high in LOAD or HOLD
- done  output  1  high in RUN (program loaded, CPU running)
- err  output  1  sticky error flag; cleared by the next accepted ld_start
- a  input  32  fetch word address (the CPU's imAddr)
- rd  output  32  fetched instruction

Behaviour:
- All outputs except rd are registered.
- Reset values: state IDLE, cpu_rst=1, ld_ready=0, busy=0, done=0, err=0, word counter=0.
- Reset does not clear RAM contents.
- Read port:
  - rd = mem[a] combinationally when a < SIZE.
  - rd = 32'h0000_0013 (addi x0,x0,0) when a >= SIZE.
  - The read port is active in every state.
- FSM states: IDLE, LOAD, HOLD, RUN.
- IDLE: cpu_rst=1, ld_ready=0.
  - On ld_start with 1 <= ld_len <= SIZE: latch ld_len, counter=0, clear err, go to LOAD.
  - On ld_start with ld_len==0 or ld_len>SIZE: set err=1, stay in IDLE.
- LOAD: ld_ready=1, busy=1, cpu_rst=1.
  - A beat is a cycle with ld_valid & ld_ready: write mem[counter]=ld_data, counter++.
  - ld_valid low means no write and the counter holds.
  - The beat where counter==len-1 writes the last word and moves to HOLD. ld_ready is 0 from the next cycle.
  - ld_start is ignored in LOAD.
- HOLD: cpu_rst=1, busy=1.
  - A hold counter is loaded with RESET_HOLD on entry and decrements each cycle.
  - Moves to RUN so that cpu_rst is first low exactly RESET_HOLD rising edges after the edge that accepted the last word.
  - ld_start is ignored in HOLD.
- RUN: cpu_rst=0, done=1, ld_ready=0.
  - ld_start with a legal ld_len reloads: next cycle is LOAD with cpu_rst=1 and done=0.
  - ld_start with an illegal ld_len: set err=1 and go to IDLE. cpu_rst=1 and done=0 from the next cycle.
- ld_valid outside LOAD is ignored and nothing is written.
- An asynchronous rst mid-LOAD or mid-HOLD aborts at once: state IDLE, cpu_rst=1. Words already written stay in RAM.
- Write/read collision in the same cycle (write to the address being read): rd shows old data until the write edge, new data after it.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds input ld_sum [31:0], latched together with ld_len on the accepted ld_start.
  - The loader keeps a running 32-bit modulo-2^32 sum of the written words; the sum is reset on each accepted ld_start.
  - After the last beat, a sum equal to ld_sum follows the normal HOLD -> RUN path.
  - On mismatch: next state IDLE, err=1, cpu_rst stays 1, done=0.
- Undefined: the ld_sum port and the adder are absent, and every completed load goes to HOLD.

Test Plan:
- Reset check: assert rst for 2 cycles -> cpu_rst=1, ld_ready=0, busy=0, done=0, err=0. a=2000 -> rd=32'h00000013.
- Basic load: ld_start with ld_len=4, then 4 back-to-back beats 0x00000513, 0x00100593, 0x00b50533, 0xff9ff06f.
  - ld_ready is high for exactly 4 cycles; rd at a=0..3 matches the words.
  - cpu_rst falls 2 edges after the 4th beat; done=1.
- Backpressure: ld_len=3 with ld_valid pattern 1,0,0,1,0,1 -> exactly 3 writes, to addresses 0,1,2; HOLD entered after the 6th cycle.
- Length errors:
  - ld_len=0 -> err=1, state stays IDLE, cpu_rst=1.
  - Then ld_len=1025 -> err stays 1.
  - Then a legal ld_start with ld_len=2 -> err=0 and LOAD is entered.
- Reload from RUN: after a load completes, ld_start with ld_len=2 -> cpu_rst=1, done=0 and ld_ready=1 on the next cycle. The new words overwrite addresses 0..1; address 2 is unchanged.
- Mid-load reset: ld_len=4, pulse rst after 2 beats -> IDLE, cpu_rst=1, ld_ready=0. mem[0..1] hold the new words.
- With LOADER_CHECKSUM_EN defined:
  - ld_sum wrong by 1 -> err=1, cpu_rst stays 1.
  - ld_sum correct -> RUN is reached.
